// File: rtl/muldiv_seq_pkg.sv
// Shared types for the MULTU/DIVU sequencer:
// ALU op codes, multiply/divide select and FSM states.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101
  } alu_op_e;

  localparam logic MD_MULTU = 1'b0;
  localparam logic MD_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_alu.sv
// Combinational add/subtract/logic ALU; the MSB of the
// result doubles as carry (ADD) and negative/borrow (SUB).
import muldiv_seq_pkg::*;

module alu #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [W-1:0] y_o,
  output logic         neg_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_NOR: y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

  assign neg_o = y_o[W-1];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer: shift-add
// multiply and restoring divide through one shared ALU.
import muldiv_seq_pkg::*;

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   alu_a, alu_b, alu_y;
  logic             alu_neg;
  alu_op_e          alu_op;

  // Divide feeds the shifted partial remainder; multiply
  // adds the multiplicand only when the multiplier LSB is set.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = {1'b0, hi_q};
    alu_b  = '0;
    if (op_q == MD_DIVU) begin
      alu_op = ALU_SUB;
      alu_a  = {hi_q, lo_q[WIDTH-1]};
      alu_b  = {1'b0, d_q};
    end else if (lo_q[0]) begin
      alu_b  = {1'b0, d_q};
    end
  end

  alu #(
    .W(WIDTH+1)
  ) u_alu (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .op_i (alu_op),
    .y_o  (alu_y),
    .neg_o(alu_neg)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    d_d     = d_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d  = op;
          d_d   = (op == MD_DIVU) ? b : a;
          dbz_d = 1'b0;
          cnt_d = CW'(WIDTH-1);
          hi_d  = '0;
          if (op == MD_MULTU) begin
            lo_d    = b;
            state_d = MD_RUN;
          end else if (b != '0) begin
            lo_d    = a;
            state_d = MD_RUN;
          end else begin
            hi_d    = a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = MD_DONE;
          end
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == MD_MULTU) begin
          hi_d = alu_y[WIDTH:1];
          lo_d = {alu_y[0], lo_q[WIDTH-1:1]};
        end else if (!alu_neg) begin
          hi_d = alu_y[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = alu_a[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MULTU;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      d_q     <= d_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != MD_IDLE);
  assign done        = (state_q == MD_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq (WIDTH=32).
// Inputs change on negedge; outputs sampled on negedge.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(dbz)
  );

  // Caller is at a negedge. Returns cycles until done and
  // the number of sampled cycles with busy high.
  task automatic run_op(input logic o, input logic [31:0] x,
                        input logic [31:0] y,
                        output int lat, output int nbusy);
    op = o; a = x; b = y; start = 1'b1;
    lat = 0; nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) nbusy++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, dbz} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, dbz});
    end
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++;
      $display("FAIL reset_hilo got=%h want=0", {hi, lo});
    end
    reset = 1'b0;
  endtask

  task automatic test_multu();
    int lat, nb;
    run_op(1'b0, 32'd3, 32'd5, lat, nb);
    total++;
    if (lat !== 33) begin
      bad++; $display("FAIL mul_latency got=%0d want=33", lat);
    end
    total++;
    if (nb !== 33) begin
      bad++; $display("FAIL mul_busy got=%0d want=33", nb);
    end
    total++;
    if ({hi, lo} !== 64'h0000_0000_0000_000F) begin
      bad++; $display("FAIL mul_3x5 got=%h want=f", {hi, lo});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'hF) begin
      bad++;
      $display("FAIL mul_after got=%b%b lo=%h want=00 lo=f", done, busy, lo);
    end
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
    total++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL mul_max got=%h want=fffffffe00000001", {hi, lo});
    end
    @(negedge clk);
    run_op(1'b0, 32'h1234_5678, 32'd0, lat, nb);
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++; $display("FAIL mul_zero got=%h want=0", {hi, lo});
    end
    @(negedge clk);
  endtask

  task automatic test_divu();
    int lat, nb;
    run_op(1'b1, 32'd100, 32'd7, lat, nb);
    total++;
    if (lat !== 33) begin
      bad++; $display("FAIL div_latency got=%0d want=33", lat);
    end
    total++;
    if (lo !== 32'd14 || hi !== 32'd2 || dbz !== 1'b0) begin
      bad++;
      $display("FAIL div_100_7 got q=%0d r=%0d z=%b want q=14 r=2 z=0",
               lo, hi, dbz);
    end
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, lat, nb);
    total++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h0) begin
      bad++;
      $display("FAIL div_max_1 got q=%h r=%h want q=ffffffff r=0", lo, hi);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, nb;
    run_op(1'b1, 32'd5, 32'd0, lat, nb);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL dbz_latency got=%0d want=1", lat);
    end
    total++;
    if (dbz !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL dbz_result got z=%b hi=%h lo=%h want z=1 hi=5 lo=ffffffff",
               dbz, hi, lo);
    end
    @(negedge clk);
    total++;
    if (dbz !== 1'b1 || hi !== 32'd5) begin
      bad++; $display("FAIL dbz_hold got z=%b hi=%h want z=1 hi=5", dbz, hi);
    end
    run_op(1'b1, 32'd9, 32'd3, lat, nb);
    total++;
    if (dbz !== 1'b0 || lo !== 32'd3 || hi !== 32'd0) begin
      bad++;
      $display("FAIL dbz_clear got z=%b q=%0d r=%0d want z=0 q=3 r=0",
               dbz, lo, hi);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat, nb;
    op = 1'b0; a = 32'h1234; b = 32'h10; start = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (done) break;
      if (lat == 5 || lat == 20) begin
        start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (lat !== 33 || {hi, lo} !== 64'h0000_0000_0001_2340) begin
      bad++;
      $display("FAIL ign_start got lat=%0d res=%h want lat=33 res=12340",
               lat, {hi, lo});
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    run_op(1'b0, 32'd7, 32'd9, lat, nb);
    @(negedge clk);
    run_op(1'b0, 32'd11, 32'd13, lat, nb);
    total++;
    if (lat !== 33 || lo !== 32'd143 || hi !== 32'd0) begin
      bad++;
      $display("FAIL b2b got lat=%0d lo=%0d want lat=33 lo=143", lat, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, nb, ndone;
    op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h0) begin
      bad++;
      $display("FAIL rst_mid got busy=%b done=%b hilo=%h want 0 0 0",
               busy, done, {hi, lo});
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++; $display("FAIL rst_no_done got=%0d want=0", ndone);
    end
    run_op(1'b0, 32'd7, 32'd6, lat, nb);
    total++;
    if (lo !== 32'd42 || hi !== 32'd0 || lat !== 33) begin
      bad++;
      $display("FAIL rst_then_mul got lo=%0d lat=%0d want lo=42 lat=33",
               lo, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
